// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between spi_ram_arbiter and its SPI slave, host port and RAM.
// slave is the arbiter's view; master is the surrounding SPI/host/RAM side.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic [9:0]           spi_rx_data;
    logic                 spi_rx_valid;
    logic [7:0]           spi_tx_data;
    logic                 spi_tx_valid;
    logic                 host_req;
    logic                 host_we;
    logic [ADDR_SIZE-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic                 host_gnt;
    logic [7:0]           host_rdata;
    logic                 host_rvalid;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;
    logic                 spi_ovf;

    modport slave (
        input  spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
    );

    modport master (
        output spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// SPI command decode and round-robin sharing of one single-port RAM between SPI and host.
// Optional feature: define SPI_RAM_ARB_AUTOINC_EN to post-increment SPI addresses per accepted access.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input logic              clk,
    input logic              rst_n,
    spi_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] OP_LD_WR = 2'b00;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_LD_RD = 2'b10;
    localparam logic [1:0] OP_RD    = 2'b11;

    if (ADDR_SIZE > 8 || MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_param_check
        $error("spi_ram_arbiter: ADDR_SIZE must be <= 8 and MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    state_t               state, state_next;
    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 cmd_mem, cmd_accept, slot_full;
    logic                 grant_spi, grant_host;

    logic                 pend, pend_we;
    logic [ADDR_SIZE-1:0] pend_addr, wr_addr, rd_addr;
    logic [7:0]           pend_wdata;
    logic                 rr_last_host, owner_host;

    logic                 ram_en, ram_we, host_gnt, spi_tx_valid, host_rvalid, spi_ovf;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_wdata, spi_tx_data, host_rdata;

`ifdef SPI_RAM_ARB_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    assign opcode       = bus.spi_rx_data[9:8];
    assign payload      = bus.spi_rx_data[7:0];
    assign payload_addr = payload[ADDR_SIZE-1:0];

    // The slot only counts as full if it is not being handed to the RAM this same cycle.
    assign cmd_mem    = bus.spi_rx_valid && (opcode == OP_WR || opcode == OP_RD);
    assign slot_full  = pend && !grant_spi;
    assign cmd_accept = cmd_mem && !slot_full;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        state_next = state;
        unique case (state)
            IDLE: begin
                grant_spi  = pend && (!bus.host_req || rr_last_host);
                grant_host = bus.host_req && !grant_spi;
                if (grant_spi || grant_host) state_next = ISSUE;
            end
            ISSUE:   state_next = ram_we ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend         <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            rr_last_host <= 1'b1;
            owner_host   <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            host_gnt     <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            spi_ovf      <= 1'b0;
        end else begin
            if (bus.spi_rx_valid) begin
                unique case (opcode)
                    OP_LD_WR: wr_addr <= payload_addr;
                    OP_LD_RD: rd_addr <= payload_addr;
                    default:  ;
                endcase
            end

            if (cmd_mem && slot_full) spi_ovf <= 1'b1;

            // The entry snapshots its address now; later address loads leave it alone.
            if (cmd_accept) begin
                pend_we    <= (opcode == OP_WR);
                pend_addr  <= (opcode == OP_WR) ? wr_addr : rd_addr;
                pend_wdata <= payload;
`ifdef SPI_RAM_ARB_AUTOINC_EN
                if (opcode == OP_WR) wr_addr <= next_addr(wr_addr);
                else                 rd_addr <= next_addr(rd_addr);
`endif
            end
            pend <= (pend && !grant_spi) || cmd_accept;

            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            host_gnt     <= 1'b0;
            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;

            if (grant_spi || grant_host) begin
                ram_en       <= 1'b1;
                owner_host   <= grant_host;
                rr_last_host <= grant_host;
                host_gnt     <= grant_host;
                ram_we       <= grant_host ? bus.host_we    : pend_we;
                ram_addr     <= grant_host ? bus.host_addr  : pend_addr;
                ram_wdata    <= grant_host ? bus.host_wdata : pend_wdata;
            end

            if (state == RESP) begin
                if (owner_host) begin
                    host_rdata  <= bus.ram_rdata;
                    host_rvalid <= 1'b1;
                end else begin
                    spi_tx_data  <= bus.ram_rdata;
                    spi_tx_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.ram_en       = ram_en;
    assign bus.ram_we       = ram_we;
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_wdata    = ram_wdata;
    assign bus.host_gnt     = host_gnt;
    assign bus.host_rdata   = host_rdata;
    assign bus.host_rvalid  = host_rvalid;
    assign bus.spi_tx_data  = spi_tx_data;
    assign bus.spi_tx_valid = spi_tx_valid;
    assign bus.spi_ovf      = spi_ovf;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: directed SPI/host traffic against a behavioural RAM,
// with expected RAM cycles and read responses queued up front and popped by a monitor.
module tb_spi_ram_arbiter;

`ifdef SPI_RAM_ARB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         gnt;
        int         cyc;
    } ram_exp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } data_exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_exp_t  ram_q[$];
    data_exp_t tx_q[$];
    data_exp_t rd_q[$];
    logic [7:0] mem [256];

    spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

    spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ram(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                            input bit gnt, input int c);
        ram_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.gnt = gnt; e.cyc = c;
        ram_q.push_back(e);
    endtask

    task automatic push_tx(input logic [7:0] data, input int c);
        data_exp_t e;
        e.data = data; e.cyc = c;
        tx_q.push_back(e);
    endtask

    task automatic push_rd(input logic [7:0] data, input int c);
        data_exp_t e;
        e.data = data; e.cyc = c;
        rd_q.push_back(e);
    endtask

    // Monitor: every observed RAM cycle or read strobe must match the head of its queue.
    initial begin
        ram_exp_t  re;
        data_exp_t de;
        forever begin
            @(negedge clk);
            if (bus.ram_en) begin
                check_eq("ram_access_expected", int'(ram_q.size() > 0), 1);
                if (ram_q.size() > 0) begin
                    re = ram_q.pop_front();
                    check_eq("ram_we", bus.ram_we, re.we);
                    check_eq("ram_addr", bus.ram_addr, re.addr);
                    if (re.we) check_eq("ram_wdata", bus.ram_wdata, re.wdata);
                    check_eq("host_gnt", bus.host_gnt, re.gnt);
                    check_eq("ram_cycle", cyc, re.cyc);
                end
            end else if (bus.host_gnt) begin
                check_eq("gnt_without_ram_en", bus.host_gnt, 0);
            end
            if (bus.spi_tx_valid) begin
                check_eq("spi_tx_expected", int'(tx_q.size() > 0), 1);
                if (tx_q.size() > 0) begin
                    de = tx_q.pop_front();
                    check_eq("spi_tx_data", bus.spi_tx_data, de.data);
                    check_eq("spi_tx_cycle", cyc, de.cyc);
                end
            end
            if (bus.host_rvalid) begin
                check_eq("host_rvalid_expected", int'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    de = rd_q.pop_front();
                    check_eq("host_rdata", bus.host_rdata, de.data);
                    check_eq("host_rvalid_cycle", cyc, de.cyc);
                end
            end
        end
    end

    task automatic spi_cmd(input logic [1:0] op, input logic [7:0] payload);
        bus.spi_rx_data  = {op, payload};
        bus.spi_rx_valid = 1'b1;
        @(negedge clk);
        bus.spi_rx_valid = 1'b0;
    endtask

    task automatic host_drive(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            if (bus.host_gnt) break;
            @(negedge clk);
        end
        check_eq("host_gnt_seen", bus.host_gnt, 1);
        bus.host_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((ram_q.size() + tx_q.size() + rd_q.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_outstanding", ram_q.size() + tx_q.size() + rd_q.size(), 0);
        ram_q.delete();
        tx_q.delete();
        rd_q.delete();
        @(negedge clk);
    endtask

    task automatic spi_read_check(input logic [7:0] addr, input logic [7:0] exp);
        int t = cyc;
        push_ram(1'b0, addr, 8'h00, 1'b0, t + 3);
        push_tx(exp, t + 5);
        spi_cmd(2'b10, addr);
        spi_cmd(2'b11, 8'h00);
        drain();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_spi_tx_data"},  bus.spi_tx_data, 0);
        check_eq({tag, "_spi_tx_valid"}, bus.spi_tx_valid, 0);
        check_eq({tag, "_host_rdata"},   bus.host_rdata, 0);
        check_eq({tag, "_host_rvalid"},  bus.host_rvalid, 0);
        check_eq({tag, "_host_gnt"},     bus.host_gnt, 0);
        check_eq({tag, "_ram_en"},       bus.ram_en, 0);
        check_eq({tag, "_ram_we"},       bus.ram_we, 0);
        check_eq({tag, "_ram_addr"},     bus.ram_addr, 0);
        check_eq({tag, "_ram_wdata"},    bus.ram_wdata, 0);
        check_eq({tag, "_spi_ovf"},      bus.spi_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n            = 1'b0;
        bus.spi_rx_data  = '0;
        bus.spi_rx_valid = 1'b0;
        bus.host_req     = 1'b0;
        bus.host_we      = 1'b0;
        bus.host_addr    = '0;
        bus.host_wdata   = '0;
        bus.ram_rdata    = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // SPI address loads, write, then read back with four-cycle latency.
        t = cyc;
        push_ram(1'b1, 8'h12, 8'hA5, 1'b0, t + 3);
        push_ram(1'b0, 8'h12, 8'h00, 1'b0, t + 5);
        push_tx(8'hA5, t + 7);
        spi_cmd(2'b00, 8'h12);
        spi_cmd(2'b01, 8'hA5);
        spi_cmd(2'b10, 8'h12);
        spi_cmd(2'b11, 8'h00);
        drain();

        // Host write then host read.
        t = cyc;
        push_ram(1'b1, 8'h30, 8'h5C, 1'b1, t + 1);
        push_ram(1'b0, 8'h30, 8'h00, 1'b1, t + 3);
        push_rd(8'h5C, t + 5);
        host_drive(1'b1, 8'h30, 8'h5C);
        wait_gnt();
        @(negedge clk);
        host_drive(1'b0, 8'h30, 8'h00);
        wait_gnt();
        drain();

        // Contention: SPI first after reset, then host wins the next contention.
        t = cyc;
        push_ram(1'b1, 8'h40, 8'h61, 1'b0, t + 3);
        push_ram(1'b1, 8'h44, 8'h77, 1'b1, t + 5);
        push_ram(1'b1, AUTOINC ? 8'h41 : 8'h40, 8'h62, 1'b0, t + 7);
        spi_cmd(2'b00, 8'h40);
        spi_cmd(2'b01, 8'h61);
        host_drive(1'b1, 8'h44, 8'h77);
        @(negedge clk);
        spi_cmd(2'b01, 8'h62);
        wait_gnt();
        drain();
        spi_read_check(8'h44, 8'h77);

        // Command arriving in the cycle the slot is consumed is accepted.
        t = cyc;
        push_ram(1'b1, 8'h50, 8'h81, 1'b0, t + 3);
        push_ram(1'b1, AUTOINC ? 8'h51 : 8'h50, 8'h82, 1'b0, t + 5);
        spi_cmd(2'b00, 8'h50);
        spi_cmd(2'b01, 8'h81);
        spi_cmd(2'b01, 8'h82);
        drain();
        check_eq("no_ovf_on_consume", bus.spi_ovf, 0);

        // Host holds the RAM while the slot is full: the second write is dropped.
        t = cyc;
        push_ram(1'b0, 8'h30, 8'h00, 1'b1, t + 1);
        push_rd(8'h5C, t + 3);
        push_ram(1'b1, 8'h60, 8'h91, 1'b0, t + 4);
        host_drive(1'b0, 8'h30, 8'h00);
        spi_cmd(2'b00, 8'h60);
        wait_gnt();
        spi_cmd(2'b01, 8'h91);
        spi_cmd(2'b01, 8'h92);
        check_eq("spi_ovf_set", bus.spi_ovf, 1);
        drain();
        spi_read_check(8'h60, 8'h91);
        t = cyc;
        push_ram(1'b1, AUTOINC ? 8'h61 : 8'h60, 8'h93, 1'b0, t + 2);
        spi_cmd(2'b01, 8'h93);
        drain();
        check_eq("spi_ovf_sticky", bus.spi_ovf, 1);

        // Reset during RESP of an SPI read abandons it silently.
        t = cyc;
        push_ram(1'b0, 8'h30, 8'h00, 1'b0, t + 3);
        spi_cmd(2'b10, 8'h30);
        spi_cmd(2'b11, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t = cyc;
        push_ram(1'b1, 8'h00, 8'hC3, 1'b0, t + 2);
        push_ram(1'b0, 8'h00, 8'h00, 1'b0, t + 4);
        push_tx(8'hC3, t + 6);
        spi_cmd(2'b01, 8'hC3);
        spi_cmd(2'b11, 8'h00);
        drain();

        // Address 0xFF followed by two writes: wraps to 0x00 only with auto-increment.
        t = cyc;
        push_ram(1'b1, 8'hFF, 8'h11, 1'b0, t + 3);
        push_ram(1'b1, AUTOINC ? 8'h00 : 8'hFF, 8'h22, 1'b0, t + 5);
        spi_cmd(2'b00, 8'hFF);
        spi_cmd(2'b01, 8'h11);
        spi_cmd(2'b01, 8'h22);
        drain();
        spi_read_check(8'hFF, AUTOINC ? 8'h11 : 8'h22);
        spi_read_check(8'h00, AUTOINC ? 8'h22 : 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
